crash_text_render: RTL and testbench

Back end of the crash-message overlay. It consumes the character-ROM address, bit index and text-region flag from the text generator, then reads the 8x16 font ROM synchronously. It selects the addressed glyph bit and emits a registered text pixel and colour to the VGA colour mux. It also owns the crash-message sequencer: a blink/hold state machine clocked by frame ticks that drives the generator's `enable` input.

---
 rtl/vga_text_pkg.sv | 15 +
 rtl/text_blink_fsm.sv | 91 +++++++++
 rtl/crash_text_render.sv | 76 +++++++
 tb/tb_crash_text_render.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_text_pkg.sv
// Shared constants and state encoding for the crash-message text overlay.
package vga_text_pkg;

    localparam int FONT_ADDR_W = 11;
    localparam int FONT_ROW_W  = 8;
    localparam int PIX_LAT     = 3;
    localparam int RGB_W       = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLASH = 2'd1,
        HOLD  = 2'd2
    } blink_state_e;

endpackage

// File: rtl/text_blink_fsm.sv
// Crash-message sequencer: blinks the text for a number of frame-tick periods,
// then holds it on until the game is restarted.
module text_blink_fsm
    import vga_text_pkg::*;
#(
    parameter int BLINK_FRAMES = 30,
    parameter int FLASH_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_tick,
    input  logic crash_event,
    input  logic clear,
    output logic text_enable
);

    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int HC_W = $clog2(2 * FLASH_CYCLES + 1);
    localparam logic [FC_W-1:0] FRAME_LAST = FC_W'(BLINK_FRAMES - 1);
    localparam logic [HC_W-1:0] HALF_LAST  = HC_W'(2 * FLASH_CYCLES);

    blink_state_e    state_q, state_d;
    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [HC_W-1:0] half_cnt_q, half_cnt_d;
    logic [HC_W-1:0] half_inc;
    logic            en_q, en_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            half_cnt_q  <= '0;
            en_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            half_cnt_q  <= half_cnt_d;
            en_q        <= en_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        half_cnt_d  = half_cnt_q;
        en_d        = en_q;
        half_inc    = half_cnt_q + 1'b1;
        // Restart wins over everything else arriving in the same cycle.
        if (clear) begin
            state_d     = IDLE;
            frame_cnt_d = '0;
            half_cnt_d  = '0;
            en_d        = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (crash_event) begin
                        state_d     = FLASH;
                        frame_cnt_d = '0;
                        half_cnt_d  = '0;
                        en_d        = 1'b1;
                    end
                end
                FLASH: begin
                    if (frame_tick) begin
                        if (frame_cnt_q == FRAME_LAST) begin
                            frame_cnt_d = '0;
                            half_cnt_d  = half_inc;
                            en_d        = ~en_q;
                            if (half_inc == HALF_LAST) begin
                                state_d = HOLD;
                                en_d    = 1'b1;
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                end
                default: begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                end
            endcase
        end
    end

    assign text_enable = en_q;

endmodule

// File: rtl/crash_text_render.sv
// Crash-overlay back end: three-stage font lookup pipeline producing a lit-text
// pixel and colour, plus the blink sequencer that gates the text generator.
module crash_text_render
    import vga_text_pkg::*;
#(
    parameter int               BLINK_FRAMES = 30,
    parameter int               FLASH_CYCLES = 3,
    parameter logic [RGB_W-1:0] TEXT_RGB     = 12'hF00
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_tick,
    input  logic                   crash_event,
    input  logic                   clear,
    input  logic                   crash_on,
    input  logic [FONT_ADDR_W-1:0] rom_addr,
    input  logic [2:0]             bit_addr,
    output logic [FONT_ADDR_W-1:0] font_addr,
    input  logic [FONT_ROW_W-1:0]  font_data,
    output logic                   text_enable,
    output logic                   text_on,
    output logic [RGB_W-1:0]       text_rgb
);

    logic [FONT_ADDR_W-1:0] font_addr_q, font_addr_d;
    logic [2:0]             bit_d1_q, bit_d1_d;
    logic [2:0]             bit_d2_q, bit_d2_d;
    logic                   on_d1_q, on_d1_d;
    logic                   on_d2_q, on_d2_d;
    logic                   text_on_q, text_on_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            font_addr_q <= '0;
            bit_d1_q    <= '0;
            bit_d2_q    <= '0;
            on_d1_q     <= 1'b0;
            on_d2_q     <= 1'b0;
            text_on_q   <= 1'b0;
        end else begin
            font_addr_q <= font_addr_d;
            bit_d1_q    <= bit_d1_d;
            bit_d2_q    <= bit_d2_d;
            on_d1_q     <= on_d1_d;
            on_d2_q     <= on_d2_d;
            text_on_q   <= text_on_d;
        end
    end

    // Stage 2 only re-times the column and flag to line up with the ROM read.
    always_comb begin
        font_addr_d = rom_addr;
        bit_d1_d    = bit_addr;
        on_d1_d     = crash_on;
        bit_d2_d    = bit_d1_q;
        on_d2_d     = on_d1_q;
        text_on_d   = on_d2_q & font_data[3'd7 - bit_d2_q];
    end

    assign font_addr = font_addr_q;
    assign text_on   = text_on_q;
    assign text_rgb  = text_on_q ? TEXT_RGB : '0;

    text_blink_fsm #(
        .BLINK_FRAMES(BLINK_FRAMES),
        .FLASH_CYCLES(FLASH_CYCLES)
    ) u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .crash_event(crash_event),
        .clear      (clear),
        .text_enable(text_enable)
    );

endmodule

// File: tb/tb_crash_text_render.sv
// Bench for crash_text_render: two sequencer configurations, a synchronous font
// ROM model, table-driven pixel vectors and randomized traffic against a model.
module tb_crash_text_render;
    import vga_text_pkg::*;

    localparam int BF_A = 2;
    localparam int FC_A = 1;
    localparam int BF_B = 3;
    localparam int FC_B = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        frame_tick = 1'b0;
    logic        crash_event = 1'b0;
    logic        clear = 1'b0;
    logic        crash_on = 1'b0;
    logic [10:0] rom_addr = '0;
    logic [2:0]  bit_addr = '0;

    logic [10:0] font_addr_a, font_addr_b;
    logic [7:0]  font_data_a, font_data_b;
    logic        text_enable_a, text_enable_b;
    logic        text_on_a, text_on_b;
    logic [11:0] text_rgb_a, text_rgb_b;

    logic [7:0]  rom_mem [0:2047];

    int n_cmp = 0;
    int n_bad = 0;

    logic [0:0]  exp_q[$];

    int m_active [2];
    int m_ticks  [2];
    int m_bf     [2];
    int m_fc     [2];

    typedef struct {
        logic        on;
        logic [10:0] addr;
        logic [2:0]  b;
        logic [7:0]  fd;
        logic        exp;
    } pix_vec_t;

    pix_vec_t tbl [24];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        font_data_a <= rom_mem[font_addr_a];
        font_data_b <= rom_mem[font_addr_b];
    end

    crash_text_render #(.BLINK_FRAMES(BF_A), .FLASH_CYCLES(FC_A), .TEXT_RGB(12'hF00)) dut_a (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .crash_event(crash_event),
        .clear(clear), .crash_on(crash_on), .rom_addr(rom_addr), .bit_addr(bit_addr),
        .font_addr(font_addr_a), .font_data(font_data_a), .text_enable(text_enable_a),
        .text_on(text_on_a), .text_rgb(text_rgb_a)
    );

    crash_text_render #(.BLINK_FRAMES(BF_B), .FLASH_CYCLES(FC_B), .TEXT_RGB(12'hF00)) dut_b (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .crash_event(crash_event),
        .clear(clear), .crash_on(crash_on), .rom_addr(rom_addr), .bit_addr(bit_addr),
        .font_addr(font_addr_b), .font_data(font_data_b), .text_enable(text_enable_b),
        .text_on(text_on_b), .text_rgb(text_rgb_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sequencer model: count qualifying ticks since the crash and derive the
    // blink phase from that count directly.
    function automatic void model_step(input bit crash, input bit tick, input bit clr);
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                m_active[k] = 0;
            end else if (m_active[k] == 0) begin
                if (crash) begin
                    m_active[k] = 1;
                    m_ticks[k]  = 0;
                end
            end else if (tick && m_ticks[k] < 2 * m_bf[k] * m_fc[k]) begin
                m_ticks[k]++;
            end
        end
    endfunction

    function automatic logic m_en(input int k);
        if (m_active[k] == 0) return 1'b0;
        if (m_ticks[k] >= 2 * m_bf[k] * m_fc[k]) return 1'b1;
        return ((m_ticks[k] / m_bf[k]) % 2) == 0;
    endfunction

    function automatic blink_state_e m_state(input int k);
        if (m_active[k] == 0) return IDLE;
        if (m_ticks[k] >= 2 * m_bf[k] * m_fc[k]) return HOLD;
        return FLASH;
    endfunction

    function automatic logic pix_ref(input logic on, input logic [10:0] addr, input logic [2:0] b);
        logic [7:0] shifted;
        shifted = rom_mem[addr] << b;
        return on & shifted[7];
    endfunction

    task automatic check_seq();
        check("en_a", 32'(text_enable_a), 32'(m_en(0)));
        check("state_a", 32'(dut_a.u_fsm.state_q), 32'(m_state(0)));
        check("en_b", 32'(text_enable_b), 32'(m_en(1)));
        check("state_b", 32'(dut_b.u_fsm.state_q), 32'(m_state(1)));
    endtask

    // Called at a falling edge; drives one cycle of control pulses.
    task automatic seq_cycle(input bit crash, input bit tick, input bit clr);
        crash_event = crash;
        frame_tick  = tick;
        clear       = clr;
        @(posedge clk);
        model_step(crash, tick, clr);
        @(negedge clk);
        crash_event = 1'b0;
        frame_tick  = 1'b0;
        clear       = 1'b0;
        check_seq();
    endtask

    task automatic pix_step(input logic on, input logic [10:0] addr, input logic [2:0] b,
                            input logic exp);
        logic e;
        crash_on = on;
        rom_addr = addr;
        bit_addr = b;
        exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 3) begin
            e = exp_q.pop_front();
            check("text_on_a", 32'(text_on_a), 32'(e));
            check("text_rgb_a", 32'(text_rgb_a), e ? 32'hF00 : 32'h0);
            check("text_on_b", 32'(text_on_b), 32'(e));
        end
    endtask

    task automatic pix_drain();
        pix_step(1'b0, 11'h0, 3'd0, 1'b0);
        pix_step(1'b0, 11'h0, 3'd0, 1'b0);
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_font_addr_a"}, 32'(font_addr_a), 32'h0);
        check({tag, "_en_a"}, 32'(text_enable_a), 32'h0);
        check({tag, "_on_a"}, 32'(text_on_a), 32'h0);
        check({tag, "_rgb_a"}, 32'(text_rgb_a), 32'h0);
        check({tag, "_font_addr_b"}, 32'(font_addr_b), 32'h0);
        check({tag, "_en_b"}, 32'(text_enable_b), 32'h0);
        check({tag, "_on_b"}, 32'(text_on_b), 32'h0);
        check({tag, "_state_a"}, 32'(dut_a.u_fsm.state_q), 32'(IDLE));
        check({tag, "_state_b"}, 32'(dut_b.u_fsm.state_q), 32'(IDLE));
    endtask

    // Text must come up exactly on the third edge after reset release.
    task automatic check_release_latency(input string tag);
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_on_a"}, 32'(text_on_a), (e == 3) ? 32'h1 : 32'h0);
            check({tag, "_on_b"}, 32'(text_on_b), (e == 3) ? 32'h1 : 32'h0);
        end
        check({tag, "_rgb_a"}, 32'(text_rgb_a), 32'hF00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit a5_exp [8];
        a5_exp = '{1, 0, 1, 0, 0, 1, 0, 1};
        m_bf = '{BF_A, BF_B};
        m_fc = '{FC_A, FC_B};
        m_active = '{0, 0};
        m_ticks  = '{0, 0};
        for (int i = 0; i < 2048; i++) rom_mem[i] = 8'h00;
        rom_mem[11'h430] = 8'h80;

        // Reset with the first test's inputs already present.
        crash_on = 1'b1;
        rom_addr = 11'h430;
        bit_addr = 3'd0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        check_release_latency("release");

        for (int i = 0; i < 8; i++) begin
            tbl[i]      = '{1'b1, 11'h430, 3'(i), 8'h80, (i == 0)};
            tbl[i + 8]  = '{1'b1, 11'h500, 3'(i), 8'hA5, a5_exp[i]};
            tbl[i + 16] = '{1'b0, 11'h500, 3'(i), 8'hA5, 1'b0};
        end
        for (int i = 0; i < 24; i++) rom_mem[tbl[i].addr] = tbl[i].fd;
        exp_q.delete();
        for (int i = 0; i < 24; i++) pix_step(tbl[i].on, tbl[i].addr, tbl[i].b, tbl[i].exp);
        pix_drain();

        for (int i = 0; i < 2048; i++) rom_mem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 80; i++) begin
            logic        on;
            logic [10:0] addr;
            logic [2:0]  b;
            on   = ($urandom_range(0, 3) != 0);
            addr = 11'($urandom_range(0, 2047));
            b    = 3'($urandom_range(0, 7));
            pix_step(on, addr, b, pix_ref(on, addr, b));
        end
        pix_drain();

        // Sequencer directed sequence.
        seq_cycle(0, 0, 0);
        seq_cycle(0, 1, 0);
        seq_cycle(1, 0, 0);
        check("evt_en_a", 32'(text_enable_a), 32'h1);
        seq_cycle(0, 1, 0);
        seq_cycle(1, 0, 0);
        seq_cycle(0, 1, 0);
        check("tick2_en_a", 32'(text_enable_a), 32'h0);
        seq_cycle(0, 0, 0);
        seq_cycle(0, 1, 0);
        seq_cycle(0, 1, 0);
        check("tick4_en_a", 32'(text_enable_a), 32'h1);
        check("tick4_state_a", 32'(dut_a.u_fsm.state_q), 32'(HOLD));
        for (int i = 0; i < 10; i++) seq_cycle(0, 1, 0);
        check("hold_en_a", 32'(text_enable_a), 32'h1);
        seq_cycle(1, 0, 1);
        check("clr_crash_state_a", 32'(dut_a.u_fsm.state_q), 32'(IDLE));
        check("clr_crash_en_a", 32'(text_enable_a), 32'h0);
        seq_cycle(1, 0, 0);
        seq_cycle(0, 1, 1);
        seq_cycle(0, 1, 0);

        for (int i = 0; i < 400; i++) begin
            seq_cycle($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 40) == 0);
        end

        // Reset mid-blink with lit pixels in flight.
        seq_cycle(0, 0, 1);
        seq_cycle(1, 0, 0);
        seq_cycle(0, 1, 0);
        rom_mem[11'h7FF] = 8'hFF;
        exp_q.delete();
        for (int i = 0; i < 4; i++) pix_step(1'b1, 11'h7FF, 3'($urandom_range(0, 7)), 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        m_active = '{0, 0};
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        check_release_latency("rerelease");
        check_seq();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
